writeback_retire: RTL and testbench

- Final pipeline stage; consumes the registered memory→writeback payload.
- Commits results to the register file.
- Counts cycles and retired instructions.
- Converts an illegal-flagged instruction into a precise machine trap: records mepc/mcause, flushes the pipeline, redirects fetch, then drains in-flight bubbles before accepting instructions again.

---
 rtl/writeback_retire.sv | 169 ++++++++++++++++
 tb/tb_writeback_retire.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_retire.sv
// -----------------------------------------------------------------------------
// writeback_retire
//
// Final pipeline stage. Takes the registered memory->writeback payload,
// commits results to the register file, counts cycles and retired
// instructions, and turns an illegal-flagged instruction into a precise
// machine trap. The trap records mepc/mcause, flushes the pipeline for one
// cycle, redirects fetch, then discards in-flight payloads for DRAIN_CYCLES
// cycles before accepting instructions again.
//
// Ports
//   clock                   single clock, all state on the rising edge
//   reset                   asynchronous, active-low reset
//   memoryWritebackPayload  registered payload from the memory stage
//   writebackStall          payload is held this cycle and must not retire
//   registerWriteEnable     register-file write strobe (combinational)
//   registerWriteAddress    destination register (pass-through)
//   registerWriteData       write data (pass-through)
//   trapFlush               one-cycle flush to all upstream stages
//   trapRedirectValid       one-cycle fetch redirect, coincident with flush
//   trapRedirectTarget      constant TRAP_VECTOR
//   trapActive              high while in FLUSH or DRAIN
//   mepc                    PC of the trapping instruction
//   mcause                  cause of the last trap
//   cycleCount              free-running 64-bit cycle counter
//   instretCount            64-bit retired-instruction counter
//   debugState              current FSM state
//
// Handshake: the payload is consumed in a cycle when valid=1, stall=0 and
// the FSM is IDLE. There is no backpressure output; outside IDLE, payloads
// are silently dropped.
// -----------------------------------------------------------------------------

package writeback_retire_pkg;

  typedef struct packed {
    logic        valid;
    logic        illegal;
    logic        writebackEnable;
    logic [31:0] data;
    logic [31:0] programCounter;
    logic [4:0]  destinationRegister;
  } mem_wb_payload_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } wb_state_e;

endpackage

module writeback_retire
  import writeback_retire_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR   = 32'h0000_0100,
  parameter logic [31:0] ILLEGAL_CAUSE = 32'd2,
  parameter int          DRAIN_CYCLES  = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  mem_wb_payload_t memoryWritebackPayload,
  input  logic            writebackStall,
  output logic            registerWriteEnable,
  output logic [4:0]      registerWriteAddress,
  output logic [31:0]     registerWriteData,
  output logic            trapFlush,
  output logic            trapRedirectValid,
  output logic [31:0]     trapRedirectTarget,
  output logic            trapActive,
  output logic [31:0]     mepc,
  output logic [31:0]     mcause,
  output logic [63:0]     cycleCount,
  output logic [63:0]     instretCount,
  output wb_state_e       debugState
);

  localparam int DRAIN_W = 4;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  wb_state_e           state_q, state_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [31:0]         mepc_q, mepc_d;
  logic [31:0]         mcause_q, mcause_d;
  logic [63:0]         cycle_q;
  logic [63:0]         instret_q, instret_d;

  logic accept;
  logic take_trap;
  logic retire;

  // Only IDLE consumes payloads; FLUSH/DRAIN drop everything, illegal or not.
  assign accept    = memoryWritebackPayload.valid && !writebackStall && (state_q == ST_IDLE);
  assign take_trap = accept && memoryWritebackPayload.illegal;
  assign retire    = accept && !memoryWritebackPayload.illegal;

  // Zero-latency register write; the reset term keeps the strobe low while
  // reset is held regardless of the payload. x0 is never written.
  assign registerWriteEnable  = reset && retire
                                && memoryWritebackPayload.writebackEnable
                                && (memoryWritebackPayload.destinationRegister != 5'd0);
  assign registerWriteAddress = memoryWritebackPayload.destinationRegister;
  assign registerWriteData    = memoryWritebackPayload.data;

  // FSM next state
  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    unique case (state_q)
      ST_IDLE: begin
        if (take_trap) begin
          state_d  = ST_FLUSH;
          mepc_d   = memoryWritebackPayload.programCounter;
          mcause_d = ILLEGAL_CAUSE;
        end
      end
      ST_FLUSH: begin
        state_d = ST_DRAIN;
        drain_d = DRAIN_LOAD;
      end
      ST_DRAIN: begin
        // Counter holds remaining drain cycles minus one, so DRAIN lasts
        // exactly DRAIN_CYCLES cycles.
        if (drain_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counters wrap silently through natural 64-bit overflow.
  assign instret_d = retire ? instret_q + 64'd1 : instret_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      drain_q   <= '0;
      mepc_q    <= '0;
      mcause_q  <= '0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
      cycle_q   <= cycle_q + 64'd1;
      instret_q <= instret_d;
    end
  end

  // Flush and redirect are decoded from the state register, so they are
  // glitch-free and last exactly the single FLUSH cycle.
  assign trapFlush          = (state_q == ST_FLUSH);
  assign trapRedirectValid  = (state_q == ST_FLUSH);
  assign trapRedirectTarget = TRAP_VECTOR;
  assign trapActive         = (state_q != ST_IDLE);
  assign mepc               = mepc_q;
  assign mcause             = mcause_q;
  assign cycleCount         = cycle_q;
  assign instretCount       = instret_q;
  assign debugState         = state_q;

endmodule

// File: tb/tb_writeback_retire.sv
// -----------------------------------------------------------------------------
// tb_writeback_retire
//
// Directed scenarios followed by randomized traffic. The reference model
// tracks the trap window as a plain count of remaining busy cycles and keeps
// the architectural values (mepc, mcause, counters) as ordinary variables.
// Inputs change on the falling edge; outputs are sampled 1ns later.
// -----------------------------------------------------------------------------

module tb_writeback_retire;
  import writeback_retire_pkg::*;

  localparam logic [31:0] TV = 32'h0000_0100;
  localparam logic [31:0] IC = 32'd2;
  localparam int          DC = 3;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_wb_payload_t pl;
  logic            stall;
  logic            registerWriteEnable;
  logic [4:0]      registerWriteAddress;
  logic [31:0]     registerWriteData;
  logic            trapFlush;
  logic            trapRedirectValid;
  logic [31:0]     trapRedirectTarget;
  logic            trapActive;
  logic [31:0]     mepc;
  logic [31:0]     mcause;
  logic [63:0]     cycleCount;
  logic [63:0]     instretCount;
  wb_state_e       debugState;

  writeback_retire #(
    .TRAP_VECTOR  (TV),
    .ILLEGAL_CAUSE(IC),
    .DRAIN_CYCLES (DC)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .memoryWritebackPayload(pl),
    .writebackStall        (stall),
    .registerWriteEnable   (registerWriteEnable),
    .registerWriteAddress  (registerWriteAddress),
    .registerWriteData     (registerWriteData),
    .trapFlush             (trapFlush),
    .trapRedirectValid     (trapRedirectValid),
    .trapRedirectTarget    (trapRedirectTarget),
    .trapActive            (trapActive),
    .mepc                  (mepc),
    .mcause                (mcause),
    .cycleCount            (cycleCount),
    .instretCount          (instretCount),
    .debugState            (debugState)
  );

  // reference model state
  logic [63:0] m_cycle;
  logic [63:0] m_instret;
  logic [31:0] m_mepc;
  logic [31:0] m_mcause;
  int          m_busy;   // cycles left in the trap window (flush + drain)
  int          n_writes; // register writes seen, for the stall scenario

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic mem_wb_payload_t mk(input logic v, input logic il, input logic we,
                                         input logic [4:0] rd, input logic [31:0] d,
                                         input logic [31:0] pc);
    mem_wb_payload_t p;
    p.valid               = v;
    p.illegal             = il;
    p.writebackEnable     = we;
    p.destinationRegister = rd;
    p.data                = d;
    p.programCounter      = pc;
    return p;
  endfunction

  task automatic model_reset();
    m_cycle   = '0;
    m_instret = '0;
    m_mepc    = '0;
    m_mcause  = '0;
    m_busy    = 0;
  endtask

  // Called at a falling edge: drive, check, advance one rising edge, update
  // the model, return at the next falling edge.
  task automatic cycle(input mem_wb_payload_t p, input logic s);
    logic acc;
    logic exp_we;
    pl    = p;
    stall = s;
    #1;
    acc    = p.valid && !s && (m_busy == 0);
    exp_we = acc && !p.illegal && p.writebackEnable && (p.destinationRegister != 5'd0);
    check("wr_en",    64'(registerWriteEnable),  64'(exp_we));
    check("wr_addr",  64'(registerWriteAddress), 64'(p.destinationRegister));
    check("wr_data",  64'(registerWriteData),    64'(p.data));
    check("flush",    64'(trapFlush),            64'(m_busy == DC + 1));
    check("redirect", 64'(trapRedirectValid),    64'(m_busy == DC + 1));
    check("target",   64'(trapRedirectTarget),   64'(TV));
    check("active",   64'(trapActive),           64'(m_busy != 0));
    check("mepc",     64'(mepc),                 64'(m_mepc));
    check("mcause",   64'(mcause),               64'(m_mcause));
    check("cycle",    cycleCount,                m_cycle);
    check("instret",  instretCount,              m_instret);
    if (registerWriteEnable) n_writes++;
    @(posedge clock);
    m_cycle = m_cycle + 64'd1;
    if (m_busy > 0) begin
      m_busy--;
    end else if (acc && p.illegal) begin
      m_busy   = DC + 1;
      m_mepc   = p.programCounter;
      m_mcause = IC;
    end
    if (acc && !p.illegal) m_instret = m_instret + 64'd1;
    @(negedge clock);
  endtask

  mem_wb_payload_t legal_p;

  initial begin
    pl    = '0;
    stall = 1'b0;
    n_writes = 0;
    model_reset();
    legal_p = mk(1'b1, 1'b0, 1'b1, 5'd7, 32'h1234_5678, 32'h0000_0010);

    // reset values while held, with a legal payload driven
    repeat (2) @(negedge clock);
    pl = legal_p;
    #1;
    check("rst_wr_en",   64'(registerWriteEnable), 64'd0);
    check("rst_flush",   64'(trapFlush),           64'd0);
    check("rst_active",  64'(trapActive),          64'd0);
    check("rst_cycle",   cycleCount,               64'd0);
    check("rst_instret", instretCount,             64'd0);
    check("rst_mepc",    64'(mepc),                64'd0);
    @(negedge clock);
    reset = 1'b1;

    // basic write to x5
    cycle(mk(1'b1, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 32'h0000_0000), 1'b0);
    // x0 write suppressed but retires
    cycle(mk(1'b1, 1'b0, 1'b1, 5'd0, 32'hCAFE_F00D, 32'h0000_0004), 1'b0);
    // stalled payload retires exactly once
    n_writes = 0;
    repeat (3) cycle(mk(1'b1, 1'b0, 1'b1, 5'd9, 32'h0BAD_F00D, 32'h0000_0008), 1'b1);
    cycle(mk(1'b1, 1'b0, 1'b1, 5'd9, 32'h0BAD_F00D, 32'h0000_0008), 1'b0);
    check("stall_writes", 64'(n_writes), 64'd1);

    // stalled illegal does not trap until accepted
    cycle(mk(1'b1, 1'b1, 1'b1, 5'd3, 32'h0, 32'h0000_0040), 1'b1);
    cycle(mk(1'b1, 1'b1, 1'b1, 5'd3, 32'h0, 32'h0000_0040), 1'b0);
    // flush + drain window: payloads discarded, including an illegal one
    cycle(legal_p, 1'b0);
    cycle(mk(1'b1, 1'b1, 1'b1, 5'd4, 32'h0, 32'h0000_0050), 1'b0);
    repeat (DC - 1) cycle(legal_p, 1'b0);
    // back-to-back trap on the first IDLE cycle overwrites mepc
    cycle(mk(1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0000_0080), 1'b0);
    cycle(legal_p, 1'b0); // FLUSH
    cycle(legal_p, 1'b0); // first DRAIN cycle

    // asynchronous reset in the middle of DRAIN
    pl = legal_p;
    #2;
    reset = 1'b0;
    #1;
    check("arst_active",  64'(trapActive),          64'd0);
    check("arst_wr_en",   64'(registerWriteEnable), 64'd0);
    check("arst_cycle",   cycleCount,               64'd0);
    check("arst_instret", instretCount,             64'd0);
    check("arst_mcause",  64'(mcause),              64'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    cycle(legal_p, 1'b0);
    cycle(legal_p, 1'b0);

    // instret wrap; cycleCount keeps its own count
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    cycle(legal_p, 1'b0);
    cycle(mk(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0), 1'b0);
    check("wrap_instret", instretCount, 64'd1 - 64'd1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      mem_wb_payload_t p;
      p = mk(($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0),
             $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
             $urandom, {$urandom_range(0, 32'h3FFF), 2'b00});
      cycle(p, ($urandom_range(0, 4) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // overall time bound
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
